bpfcap_dma_seq: RTL and testbench
=================================

// Module: bpfcap_dma_seq
// PURPOSE
//  Sequences the bpfcap packet datapath. Copies the word range [pkt_begin, pkt_end) from the m0 read master
//  to dst_addr on the m1 write master. Splits the range into Avalon-MM bursts of up to MAX_BURST words.
//  Stores and forwards each burst through a MAX_BURST-deep buffer. Configured by host via CSR slave s0.
// PARAMETERS
//  ADDR_W     32  byte-address width of s0 registers and m0/m1 addresses
//  MAX_BURST   8  max words per burst; power of 2, 1..256; sets buffer depth
//  CNT_W      16  width of words-copied counter and burstcount ports
// PORTS
//  clk                   in   1       single clock; all logic on rising edge
//  reset                 in   1       asynchronous, active-low reset
//  avs_s0_address        in   3       CSR word index
//  avs_s0_read           in   1       CSR read strobe
//  avs_s0_write          in   1       CSR write strobe
//  avs_s0_writedata      in   32      CSR write data
//  avs_s0_readdata       out  32      CSR read data, 1-cycle latency
//  avs_m0_address        out  ADDR_W  read burst start byte address
//  avs_m0_read           out  1       read request
//  avs_m0_burstcount     out  CNT_W   read burst length, words
//  avs_m0_waitrequest    in   1       read command stall
//  avs_m0_readdata       in   32      read beat data
//  avs_m0_readdatavalid  in   1       read beat valid
//  avs_m1_address        out  ADDR_W  write burst start byte address
//  avs_m1_write          out  1       write request
//  avs_m1_burstcount     out  CNT_W   write burst length, words
//  avs_m1_writedata      out  32      write beat data
//  avs_m1_waitrequest    in   1       write beat stall
//  irq                   out  1       completion interrupt (BPFCAP_DMA_IRQ_EN only)
// BEHAVIOUR
//  CSR map:
//   0 control: b0 start (self-clearing), b1 abort (self-clearing), b2 irq_en
//   1 pkt_begin
//   2 pkt_end
//   3 dst_addr
//   4 status (RO except W1C b1): b0 busy, b1 done, b2 err, b3 aborted, [31:16] words copied
//   5-7: read 0, writes ignored
//  Reset: all registers, outputs, FSM and counters clear to 0; FSM goes to IDLE.
//  Reset mid-transfer abandons the transfer immediately; no drain.
//  CSR writes to regs 1-3 while busy are ignored. Start while busy is ignored.
//  Start in IDLE clears done/err/aborted/count, then validates the range:
//   - if pkt_end <= pkt_begin, or either address is not word aligned (bits [1:0] != 0):
//     err=1, no bus activity, stays IDLE.
//   - otherwise remaining = (pkt_end - pkt_begin) >> 2 and the FSM enters RD_REQ.
//  FSM:
//   IDLE -> RD_REQ -> RD_DATA -> WR_BURST -> (RD_REQ | IDLE)
//   RD_REQ:   len = min(remaining, MAX_BURST). Drive m0_read=1, m0_address=src, m0_burstcount=len.
//             Hold all three stable until the cycle m0_waitrequest=0, then go to RD_DATA.
//   RD_DATA:  push each readdatavalid beat into the buffer; after len beats go to WR_BURST.
//             Beats arriving in the command-accept cycle are not expected and are ignored.
//   WR_BURST: m1_write=1, m1_address=dst, m1_burstcount=len; writedata = buffer head.
//             Each cycle with m1_waitrequest=0 pops one beat and increments count.
//             After len beats: src += 4*len, dst += 4*len, remaining -= len.
//             Next state RD_REQ if remaining > 0 and no abort pending; otherwise IDLE.
//  Abort: sets abort_pending; honoured only at the WR_BURST end boundary, so no bus burst is truncated.
//   Abort in IDLE has no effect.
//   On an honoured abort: aborted=1, done=0. Otherwise on normal completion: done=1.
//  busy=1 in every state except IDLE. m0_read/m1_write are 0 outside RD_REQ/WR_BURST.
//  Address arithmetic wraps modulo 2^ADDR_W. count saturates at 2^CNT_W-1.
// CONFIGURATION
//  BPFCAP_DMA_IRQ_EN defined: irq is registered; rises the cycle after done or aborted sets, if irq_en=1.
//   irq stays high until status b1 is written 1 or the next start.
//  Undefined: irq port still present but tied 0; control b2 reads 0.
// TESTING
//  1. Release reset -> all CSRs read 0; m0_read=0, m1_write=0, irq=0.
//  2. begin=0x20, end=0x28, dst=0x100, start; slave returns 10,11
//     -> m0 burst {0x20, cnt 2}, m1 burst {0x100, cnt 2}, writes 10,11; status = done, count 2.
//  3. begin=0x00, end=0x60, MAX_BURST=8 -> reads at 0x00/0x20/0x40 cnt 8; writes at dst/+0x20/+0x40; count 24.
//  4. m0 and m1 waitrequest held 3 cycles each beat -> address/burstcount/writedata stable; no beat lost or duplicated.
//  5. end==begin, then end=0x22 (misaligned) -> err=1 in both cases, no m0_read pulse.
//  6. 24-word job, abort during first RD_DATA -> first burst fully written, then IDLE; aborted=1, count=8;
//     with BPFCAP_DMA_IRQ_EN and irq_en=1, irq=1 until status b1 W1C.

Source files
------------

// File: rtl/bpfcap_dma_seq.sv
// bpfcap_dma_seq: copies words [pkt_begin, pkt_end) from m0 to dst_addr on m1
// in bursts of up to MAX_BURST words, store-and-forward, with CSR slave s0.
//
// Ports: clk, reset (async, active-low); s0 CSR slave (address/read/write/
// writedata/readdata, 1-cycle read latency); m0 Avalon-MM burst read master;
// m1 Avalon-MM burst write master; irq (completion interrupt).
// Macro BPFCAP_DMA_IRQ_EN: enables the registered irq and control b2 irq_en.
// When undefined, irq is tied 0 and control b2 reads 0.
module bpfcap_dma_seq #(
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        avs_s0_address,
  input  logic              avs_s0_read,
  input  logic              avs_s0_write,
  input  logic [31:0]       avs_s0_writedata,
  output logic [31:0]       avs_s0_readdata,
  output logic [ADDR_W-1:0] avs_m0_address,
  output logic              avs_m0_read,
  output logic [CNT_W-1:0]  avs_m0_burstcount,
  input  logic              avs_m0_waitrequest,
  input  logic [31:0]       avs_m0_readdata,
  input  logic              avs_m0_readdatavalid,
  output logic [ADDR_W-1:0] avs_m1_address,
  output logic              avs_m1_write,
  output logic [CNT_W-1:0]  avs_m1_burstcount,
  output logic [31:0]       avs_m1_writedata,
  input  logic              avs_m1_waitrequest,
  output logic              irq
);

  localparam int IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int LW = $clog2(MAX_BURST + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_REQ   = 2'd1;
  localparam logic [1:0] RD_DATA  = 2'd2;
  localparam logic [1:0] WR_BURST = 2'd3;

  logic [1:0]        st;
  logic [ADDR_W-1:0] pkt_begin;
  logic [ADDR_W-1:0] pkt_end;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] remaining;
  logic [LW-1:0]     len;
  logic [LW-1:0]     bcnt;
  logic [CNT_W-1:0]  count;
  logic              done;
  logic              err;
  logic              aborted;
  logic              abort_pending;
  logic [31:0]       mem [MAX_BURST];

  logic              busy;
  logic              ctrl_wr;
  logic              start_wr;
  logic              abort_wr;
  logic              w1c_done;
  logic              bad;
  logic [ADDR_W-1:0] words;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] rem_next;
  logic              last_rd;
  logic              last_wr;
  logic              abort_now;
  logic              stop;
  logic              fin;
  logic [15:0]       cnt16;
  logic              ien_bit;

  function automatic logic [LW-1:0] min_len(input logic [ADDR_W-1:0] r);
    return (r > ADDR_W'(MAX_BURST)) ? LW'(MAX_BURST) : LW'(r);
  endfunction

  assign busy     = (st != IDLE);
  assign ctrl_wr  = avs_s0_write && (avs_s0_address == 3'd0);
  assign start_wr = ctrl_wr && avs_s0_writedata[0];
  assign abort_wr = ctrl_wr && avs_s0_writedata[1];
  assign w1c_done = avs_s0_write && (avs_s0_address == 3'd4)
                    && avs_s0_writedata[1];

  assign bad = (pkt_end <= pkt_begin) || (pkt_begin[1:0] != 2'b00)
               || (pkt_end[1:0] != 2'b00);
  assign words    = (pkt_end - pkt_begin) >> 2;
  assign step     = ADDR_W'(len) << 2;
  assign rem_next = remaining - ADDR_W'(len);

  assign last_rd   = avs_m0_readdatavalid && (bcnt == len - LW'(1));
  assign last_wr   = !avs_m1_waitrequest && (bcnt == len - LW'(1));
  // An abort written in the very last beat cycle still counts.
  assign abort_now = abort_pending || abort_wr;
  assign stop      = (rem_next == '0) || abort_now;
  assign fin       = (st == WR_BURST) && last_wr && stop;

  assign avs_m0_read       = (st == RD_REQ);
  assign avs_m0_address    = src;
  assign avs_m0_burstcount = CNT_W'(len);
  assign avs_m1_write      = (st == WR_BURST);
  assign avs_m1_address    = dst;
  assign avs_m1_burstcount = CNT_W'(len);
  assign avs_m1_writedata  = mem[bcnt[IW-1:0]];

  assign cnt16 = 16'(count);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_BURST; i++) mem[i] <= '0;
    end else if (st == RD_DATA && avs_m0_readdatavalid) begin
      mem[bcnt[IW-1:0]] <= avs_m0_readdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st            <= IDLE;
      pkt_begin     <= '0;
      pkt_end       <= '0;
      dst_addr      <= '0;
      src           <= '0;
      dst           <= '0;
      remaining     <= '0;
      len           <= '0;
      bcnt          <= '0;
      count         <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      aborted       <= 1'b0;
      abort_pending <= 1'b0;
    end else begin
      if (avs_s0_write && !busy) begin
        case (avs_s0_address)
          3'd1:    pkt_begin <= ADDR_W'(avs_s0_writedata);
          3'd2:    pkt_end   <= ADDR_W'(avs_s0_writedata);
          3'd3:    dst_addr  <= ADDR_W'(avs_s0_writedata);
          default: ;
        endcase
      end
      if (w1c_done) done <= 1'b0;
      if (abort_wr && busy) abort_pending <= 1'b1;
      unique case (1'b1)
        st == IDLE: begin
          abort_pending <= 1'b0;
          if (start_wr) begin
            done    <= 1'b0;
            err     <= 1'b0;
            aborted <= 1'b0;
            count   <= '0;
            if (bad) begin
              err <= 1'b1;
            end else begin
              src       <= pkt_begin;
              dst       <= dst_addr;
              remaining <= words;
              len       <= min_len(words);
              bcnt      <= '0;
              st        <= RD_REQ;
            end
          end
        end
        st == RD_REQ: begin
          if (!avs_m0_waitrequest) begin
            bcnt <= '0;
            st   <= RD_DATA;
          end
        end
        st == RD_DATA: begin
          if (avs_m0_readdatavalid) begin
            bcnt <= bcnt + LW'(1);
            if (last_rd) begin
              bcnt <= '0;
              st   <= WR_BURST;
            end
          end
        end
        st == WR_BURST: begin
          if (!avs_m1_waitrequest) begin
            bcnt <= bcnt + LW'(1);
            if (count != '1) count <= count + CNT_W'(1);
            if (last_wr) begin
              bcnt      <= '0;
              src       <= src + step;
              dst       <= dst + step;
              remaining <= rem_next;
              if (stop) begin
                st            <= IDLE;
                abort_pending <= 1'b0;
                if (abort_now) begin
                  aborted <= 1'b1;
                  done    <= 1'b0;
                end else begin
                  done <= 1'b1;
                end
              end else begin
                len <= min_len(rem_next);
                st  <= RD_REQ;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BPFCAP_DMA_IRQ_EN
  logic irq_en;
  logic fin_q;
  logic irq_q;

  assign ien_bit = irq_en;
  assign irq     = irq_q;

  // irq follows the done/aborted flag by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en <= 1'b0;
      fin_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= avs_s0_writedata[2];
      fin_q <= fin;
      if (w1c_done || (start_wr && !busy)) begin
        irq_q <= 1'b0;
      end else if (fin_q && irq_en) begin
        irq_q <= 1'b1;
      end
    end
  end
`else
  assign ien_bit = 1'b0;
  assign irq     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avs_s0_readdata <= '0;
    end else if (avs_s0_read) begin
      case (avs_s0_address)
        3'd0:    avs_s0_readdata <= {29'd0, ien_bit, 2'b00};
        3'd1:    avs_s0_readdata <= 32'(pkt_begin);
        3'd2:    avs_s0_readdata <= 32'(pkt_end);
        3'd3:    avs_s0_readdata <= 32'(dst_addr);
        3'd4:    avs_s0_readdata <= {cnt16, 12'd0, aborted, err, done, busy};
        default: avs_s0_readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bpfcap_dma_seq.sv
// tb_bpfcap_dma_seq: randomized scoreboard bench for bpfcap_dma_seq.
// Job-level model predicts m0 commands and m1 beats; monitors compare.
module tb_bpfcap_dma_seq;

  localparam int MB = 8;
`ifdef BPFCAP_DMA_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  s0_addr = '0;
  logic        s0_rd = 1'b0;
  logic        s0_wr = 1'b0;
  logic [31:0] s0_wdata = '0;
  logic [31:0] s0_rdata;
  logic [31:0] m0_addr;
  logic        m0_read;
  logic [15:0] m0_cnt;
  logic        m0_wait = 1'b0;
  logic [31:0] m0_rdata = '0;
  logic        m0_rdv = 1'b0;
  logic [31:0] m1_addr;
  logic        m1_write;
  logic [15:0] m1_cnt;
  logic [31:0] m1_wdata;
  logic        m1_wait = 1'b0;
  logic        irq;

  bpfcap_dma_seq dut (
    .clk                  (clk),
    .reset                (reset),
    .avs_s0_address       (s0_addr),
    .avs_s0_read          (s0_rd),
    .avs_s0_write         (s0_wr),
    .avs_s0_writedata     (s0_wdata),
    .avs_s0_readdata      (s0_rdata),
    .avs_m0_address       (m0_addr),
    .avs_m0_read          (m0_read),
    .avs_m0_burstcount    (m0_cnt),
    .avs_m0_waitrequest   (m0_wait),
    .avs_m0_readdata      (m0_rdata),
    .avs_m0_readdatavalid (m0_rdv),
    .avs_m1_address       (m1_addr),
    .avs_m1_write         (m1_write),
    .avs_m1_burstcount    (m1_cnt),
    .avs_m1_writedata     (m1_wdata),
    .avs_m1_waitrequest   (m1_wait),
    .irq                  (irq)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [15:0] c; } cmd_t;
  typedef struct { logic [31:0] a; logic [15:0] c; logic [31:0] d; } beat_t;

  cmd_t  exp_rd[$];
  beat_t exp_wr[$];
  cmd_t  rsp_q[$];

  int          n_chk = 0;
  int          n_fail = 0;
  int          rd_acc = 0;
  int          stall_mode = 0;
  int          cyc = 0;
  logic [31:0] salt = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a >> 2) + 32'd2 + salt;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Slave side: wait-states and read beats.
  logic [31:0] cur_a = '0;
  int          cur_left = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    m0_rdv = 1'b0;
    if (!reset) begin
      m0_wait = 1'b0;
      m1_wait = 1'b0;
      cur_left = 0;
      rsp_q.delete();
    end else begin
      if (stall_mode != 0) begin
        m0_wait = (cyc % 4 != 0);
        m1_wait = (cyc % 4 != 2);
      end else begin
        m0_wait = ($urandom % 3 == 0);
        m1_wait = ($urandom % 3 == 0);
      end
      if (cur_left == 0 && rsp_q.size() > 0) begin
        cmd_t c;
        c = rsp_q.pop_front();
        cur_a = c.a;
        cur_left = int'(c.c);
      end
      if (cur_left > 0 && ($urandom % 4 != 0)) begin
        m0_rdv = 1'b1;
        m0_rdata = memf(cur_a);
        cur_a += 32'd4;
        cur_left--;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transfer.
  logic [31:0] p0a, p1a, p1d;
  logic [15:0] p0c, p1c;
  bit          p0s = 1'b0;
  bit          p1s = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      p0s = 1'b0;
      p1s = 1'b0;
    end else begin
      if (p0s) begin
        check("m0_hold_read", 32'(m0_read), 32'd1);
        check("m0_hold_addr", m0_addr, p0a);
        check("m0_hold_cnt", 32'(m0_cnt), 32'(p0c));
      end
      if (p1s) begin
        check("m1_hold_write", 32'(m1_write), 32'd1);
        check("m1_hold_addr", m1_addr, p1a);
        check("m1_hold_cnt", 32'(m1_cnt), 32'(p1c));
        check("m1_hold_data", m1_wdata, p1d);
      end
      p0s = m0_read && m0_wait;
      p0a = m0_addr;
      p0c = m0_cnt;
      p1s = m1_write && m1_wait;
      p1a = m1_addr;
      p1c = m1_cnt;
      p1d = m1_wdata;
      if (m0_read && !m0_wait) begin
        cmd_t e;
        cmd_t g;
        rd_acc++;
        if (exp_rd.size() == 0) begin
          check("m0_unexpected_cmd", m0_addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_rd.pop_front();
          check("m0_addr", m0_addr, e.a);
          check("m0_cnt", 32'(m0_cnt), 32'(e.c));
        end
        g.a = m0_addr;
        g.c = m0_cnt;
        rsp_q.push_back(g);
      end
      if (m1_write && !m1_wait) begin
        beat_t w;
        if (exp_wr.size() == 0) begin
          check("m1_unexpected_beat", m1_addr, 32'hFFFF_FFFF);
        end else begin
          w = exp_wr.pop_front();
          check("m1_addr", m1_addr, w.a);
          check("m1_cnt", 32'(m1_cnt), 32'(w.c));
          check("m1_data", m1_wdata, w.d);
        end
      end
    end
  end

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    s0_addr = a;
    s0_wdata = d;
    s0_wr = 1'b1;
    @(posedge clk);
    #1;
    s0_wr = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk);
    #1;
    s0_addr = a;
    s0_rd = 1'b1;
    @(posedge clk);
    #1;
    s0_rd = 1'b0;
    @(negedge clk);
    d = s0_rdata;
  endtask

  task automatic run_job(input logic [31:0] b, input logic [31:0] e,
                         input logic [31:0] d, input bit ab,
                         input bit ien, input bit lock_chk);
    int          n;
    int          k;
    int          len;
    int          wexp;
    int          rd_before;
    bit          bad;
    bit          ab_eff;
    logic [31:0] st;
    logic [31:0] r;
    logic [31:0] cw;
    bad = (e <= b) || (b[1:0] != 2'b00) || (e[1:0] != 2'b00);
    wexp = 0;
    ab_eff = 1'b0;
    if (!bad) begin
      n = int'((e - b) >> 2);
      k = 0;
      while (k < n) begin
        len = (n - k > MB) ? MB : n - k;
        exp_rd.push_back('{b + 32'(4 * k), 16'(len)});
        for (int i = 0; i < len; i++)
          exp_wr.push_back('{d + 32'(4 * k), 16'(len),
                             memf(b + 32'(4 * (k + i)))});
        k += len;
        wexp += len;
        if (ab) begin
          ab_eff = 1'b1;
          break;
        end
      end
    end
    cw = {29'd0, ien, 2'b00};
    csr_wr(3'd1, b);
    csr_wr(3'd2, e);
    csr_wr(3'd3, d);
    rd_before = rd_acc;
    csr_wr(3'd0, cw | 32'd1);
    if (lock_chk && !bad) csr_wr(3'd1, 32'hDEAD_0000);
    if (ab && !bad) begin
      for (int c = 0; c < 500 && rd_acc == rd_before; c++) @(posedge clk);
      csr_wr(3'd0, cw | 32'd2);
    end
    st = 32'd1;
    for (int c = 0; c < 2000 && st[0]; c++) csr_rd(3'd4, st);
    check("job_idle", 32'(st[0]), 32'd0);
    check("status", st, {16'(wexp), 12'd0, ab_eff, bad,
                         !bad && !ab_eff, 1'b0});
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    if (bad) check("no_m0_on_err", 32'(rd_acc), 32'(rd_before));
    if (lock_chk && !bad) begin
      csr_rd(3'd1, r);
      check("reg_locked_busy", r, b);
    end
    csr_rd(3'd0, r);
    check("ctrl_rd", r, {29'd0, IRQ_ON & ien, 2'b00});
    check("irq_after_job", 32'(irq), 32'(IRQ_ON & ien & !bad));
    csr_wr(3'd4, 32'd2);
    csr_rd(3'd4, r);
    check("status_w1c", r, {16'(wexp), 12'd0, ab_eff, bad, 2'b00});
    check("irq_after_w1c", 32'(irq), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] b;
    int          n;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_m0_read", 32'(m0_read), 32'd0);
    check("rst_m1_write", 32'(m1_write), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    for (int i = 0; i < 8; i++) begin
      csr_rd(3'(i), r);
      check("rst_csr", r, 32'd0);
    end

    salt = 32'd0;
    run_job(32'h20, 32'h28, 32'h100, 1'b0, 1'b1, 1'b0);

    salt = $urandom;
    run_job(32'h00, 32'h60, 32'h1000, 1'b0, 1'b0, 1'b1);

    stall_mode = 1;
    salt = $urandom;
    run_job(32'h400, 32'h460, 32'h2000, 1'b0, 1'b1, 1'b0);
    stall_mode = 0;

    run_job(32'h40, 32'h40, 32'h300, 1'b0, 1'b1, 1'b0);
    run_job(32'h20, 32'h22, 32'h300, 1'b0, 1'b1, 1'b0);

    salt = $urandom;
    run_job(32'h00, 32'h60, 32'h800, 1'b1, 1'b1, 1'b0);

    csr_rd(3'd4, b);
    csr_wr(3'd0, 32'd2);
    csr_rd(3'd4, r);
    check("abort_idle_noop", r, b);

    salt = $urandom;
    run_job(32'h100, 32'h130, 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      salt = $urandom;
      n = $urandom_range(1, 40);
      b = $urandom & 32'h0000_FFFC;
      run_job(b, b + 32'(4 * n), $urandom & 32'hFFFF_FFFC,
              1'b0, 1'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
